// File: rtl/ccc_cfg_pkg.sv
// Shared definitions for the CCC APB configuration master: bus widths, the lock-drop
// window length and the controller state encoding.
package ccc_cfg_pkg;

    localparam int unsigned CCC_ADDR_W       = 6;
    localparam int unsigned CCC_DATA_W       = 8;
    localparam int unsigned LOCK_DROP_CYCLES = 8;
    localparam int unsigned DROP_CNT_W       = $clog2(LOCK_DROP_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StWaitBusy,
        StSetup,
        StAccess,
        StLockWait,
        StResp
    } ccc_state_e;

endpackage

// File: rtl/ccc_lock_sync.sv
// Multi-flop synchronizer bringing the CCC's asynchronous LOCK status into the PCLK domain.
module ccc_lock_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic lock_i,
    output logic lock_s_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_i};
        end
    end

    assign lock_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_apb_cfg_master.sv
// Command-driven APB initiator for CCC configuration registers, with optional post-write
// re-lock wait. Define CCC_CFG_LOCK_TIMEOUT_EN to bound the lock wait by LOCK_TIMEOUT cycles.
module ccc_apb_cfg_master
    import ccc_cfg_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [CCC_ADDR_W-1:0] cmd_addr,
    input  logic [CCC_DATA_W-1:0] cmd_wdata,
    input  logic                  cmd_lockwait,
    output logic                  rsp_valid,
    output logic [CCC_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_lock_ok,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [CCC_ADDR_W-1:0] PADDR,
    output logic [CCC_DATA_W-1:0] PWDATA,
    input  logic [CCC_DATA_W-1:0] PRDATA,
    input  logic                  BUSY,
    input  logic                  LOCK
);

    localparam logic [DROP_CNT_W-1:0] DropLast = DROP_CNT_W'(LOCK_DROP_CYCLES - 1);

    ccc_state_e            state_q;
    logic                  write_q;
    logic                  lockwait_q;
    logic [CCC_ADDR_W-1:0] addr_q;
    logic [CCC_DATA_W-1:0] wdata_q;
    logic                  lock_armed_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  lock_s;
    logic                  tmo_hit;
    logic                  lock_done;

    ccc_lock_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i   (PCLK),
        .rst_ni  (PRESET_N),
        .lock_i  (LOCK),
        .lock_s_o(lock_s)
    );

    assign cmd_ready = (state_q == StIdle);
    // Lock is only honoured once the drop window has closed.
    assign lock_done = lock_armed_q && lock_s;

`ifdef CCC_CFG_LOCK_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        rsp_timeout_q;

    assign tmo_hit     = (tmo_cnt_q == 16'(LOCK_TIMEOUT - 1));
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge PCLK) begin
        if (!PRESET_N || state_q != StLockWait) begin
            tmo_cnt_q <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            rsp_timeout_q <= 1'b0;
        end else if (state_q == StLockWait && !lock_done && tmo_hit) begin
            rsp_timeout_q <= 1'b1;
        end else if ((state_q == StAccess && !(write_q && lockwait_q)) ||
                     (state_q == StLockWait && lock_done)) begin
            rsp_timeout_q <= 1'b0;
        end
    end
`else
    logic unused_lock_timeout;

    assign tmo_hit             = 1'b0;
    assign rsp_timeout         = 1'b0;
    assign unused_lock_timeout = ^LOCK_TIMEOUT;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            state_q      <= StIdle;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_lock_ok  <= 1'b0;
            write_q      <= 1'b0;
            lockwait_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lock_armed_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        write_q    <= cmd_write;
                        lockwait_q <= cmd_lockwait;
                        addr_q     <= cmd_addr;
                        wdata_q    <= cmd_wdata;
                        state_q    <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (!BUSY) begin
                        state_q <= StSetup;
                        PSEL    <= 1'b1;
                        PADDR   <= addr_q;
                        PWRITE  <= write_q;
                        PWDATA  <= wdata_q;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    PENABLE <= 1'b1;
                end
                StAccess: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    if (write_q && lockwait_q) begin
                        state_q      <= StLockWait;
                        lock_armed_q <= 1'b0;
                        drop_cnt_q   <= '0;
                    end else begin
                        state_q     <= StResp;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= write_q ? '0 : PRDATA;
                        rsp_lock_ok <= 1'b0;
                    end
                end
                StLockWait: begin
                    if (lock_done || tmo_hit) begin
                        state_q     <= StResp;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_lock_ok <= lock_done;
                    end else if (!lock_armed_q) begin
                        // Drop window: give the CCC time to deassert LOCK after the write.
                        if (!lock_s || drop_cnt_q == DropLast) begin
                            lock_armed_q <= 1'b1;
                        end else begin
                            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Self-checking bench for ccc_apb_cfg_master: timeline-based reference model compared every
// cycle, directed literal checks, then randomized commands. Honours CCC_CFG_LOCK_TIMEOUT_EN.
module tb_ccc_apb_cfg_master;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 50;
    localparam int          DROP = 8;
`ifdef CCC_CFG_LOCK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       PCLK = 1'b0;
    logic       PRESET_N = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0, cmd_lockwait = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0, PRDATA = '0;
    logic       BUSY = 1'b0, LOCK = 1'b1;
    logic       cmd_ready, rsp_valid, rsp_lock_ok, rsp_timeout;
    logic [7:0] rsp_rdata, PWDATA;
    logic       PSEL, PENABLE, PWRITE;
    logic [5:0] PADDR;

    ccc_apb_cfg_master #(
        .LOCK_TIMEOUT(TMO),
        .SYNC_STAGES (SYNC)
    ) dut (
        .PCLK        (PCLK),
        .PRESET_N    (PRESET_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_lockwait(cmd_lockwait),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_lock_ok (rsp_lock_ok),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .BUSY        (BUSY),
        .LOCK        (LOCK)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic bound_fail(input string name, input int limit);
        n_checks++;
        $display("FAIL %s: nothing within %0d cycles, expected an event", name, limit);
    endtask

    // Background input drivers
    bit prdata_fix   = 1'b0;
    int lock_drop_at = -1;
    int lock_rise_at = -1;
    always @(posedge PCLK) begin
        #1;
        PRDATA = prdata_fix ? 8'h5C : 8'($urandom);
        if (cyc == lock_drop_at) LOCK = 1'b0;
        if (cyc == lock_rise_at) LOCK = 1'b1;
    end

    // Per-cycle output logs for the directed literal checks
    logic       log_psel[int], log_pen[int], log_pwrite[int], log_lock_ok[int], log_tmo[int];
    logic [5:0] log_paddr[int];
    logic [7:0] log_pwdata[int], log_rdata[int];

    // Reference model: each command is a timeline of cycle numbers derived from the inputs
    bit         m_ok = 1'b0, m_busy = 1'b0, m_w = 1'b0, m_lw = 1'b0, lock_s;
    logic [5:0] m_a = '0, e_paddr = '0;
    logic [7:0] m_d = '0, e_pwdata = '0, e_rdata = '0;
    logic       e_pwrite = 1'b0, e_lock_ok = 1'b0, e_tmo = 1'b0;
    int         t_setup = -1, t_lw = -1, t_p2 = -1, t_resp = -1;
    bit         lock_q[$];

    always @(negedge PCLK) begin
        log_psel[cyc] = PSEL;       log_pen[cyc] = PENABLE;   log_pwrite[cyc] = PWRITE;
        log_paddr[cyc] = PADDR;     log_pwdata[cyc] = PWDATA; log_rdata[cyc] = rsp_rdata;
        log_lock_ok[cyc] = rsp_lock_ok; log_tmo[cyc] = rsp_timeout;
        lock_s = (lock_q.size() >= SYNC) ? lock_q[lock_q.size() - SYNC] : 1'b0;
        if (m_ok) begin
            check("cmd_ready", cmd_ready, !m_busy);
            check("PSEL", PSEL, m_busy && t_setup >= 0 && (cyc == t_setup || cyc == t_setup + 1));
            check("PENABLE", PENABLE, m_busy && t_setup >= 0 && cyc == t_setup + 1);
            check("rsp_valid", rsp_valid, m_busy && cyc == t_resp);
            check("PADDR", PADDR, e_paddr);
            check("PWDATA", PWDATA, e_pwdata);
            check("PWRITE", PWRITE, e_pwrite);
            check("rsp_rdata", rsp_rdata, e_rdata);
            check("rsp_lock_ok", rsp_lock_ok, e_lock_ok);
            check("rsp_timeout", rsp_timeout, e_tmo);
        end
        if (!PRESET_N) begin
            m_ok = 1'b1; m_busy = 1'b0;
            e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0;
            e_rdata = '0; e_lock_ok = 1'b0; e_tmo = 1'b0;
            lock_q = {};
            for (int i = 0; i < SYNC; i++) lock_q.push_back(1'b0);
        end else begin
            if (m_ok) begin
                if (!m_busy) begin
                    if (cmd_valid) begin
                        m_busy = 1'b1; m_w = cmd_write; m_lw = cmd_lockwait;
                        m_a = cmd_addr; m_d = cmd_wdata;
                        t_setup = -1; t_lw = -1; t_p2 = -1; t_resp = -1;
                    end
                end else if (cyc == t_resp) begin
                    m_busy = 1'b0;
                end else if (t_setup < 0) begin
                    if (!BUSY) begin
                        t_setup = cyc + 1; e_paddr = m_a; e_pwdata = m_d; e_pwrite = m_w;
                    end
                end else if (cyc == t_setup + 1) begin
                    if (m_w && m_lw) t_lw = cyc + 1;
                    else begin
                        t_resp = cyc + 1; e_rdata = m_w ? 8'h00 : PRDATA;
                        e_lock_ok = 1'b0; e_tmo = 1'b0;
                    end
                end else if (t_lw >= 0 && cyc >= t_lw && t_resp < 0) begin
                    if (t_p2 >= 0 && lock_s) begin
                        t_resp = cyc + 1; e_rdata = '0; e_lock_ok = 1'b1; e_tmo = 1'b0;
                    end else if (TMO_EN && cyc - t_lw == int'(TMO) - 1) begin
                        t_resp = cyc + 1; e_rdata = '0; e_lock_ok = 1'b0; e_tmo = 1'b1;
                    end else if (t_p2 < 0 && (!lock_s || cyc - t_lw == DROP - 1)) begin
                        t_p2 = cyc + 1;
                    end
                end
            end
            lock_q.push_back(LOCK);
            if (lock_q.size() > 8) void'(lock_q.pop_front());
        end
    end

    // Present a command, wait for its handshake, then hold BUSY high for busy_n cycles.
    // lock_off/lock_len schedule a LOCK drop relative to the handshake cycle (-1 = none).
    task automatic send(input bit w, input logic [5:0] a, input logic [7:0] d, input bit lw,
                        input int busy_n, input int lock_off, input int lock_len,
                        output int hs);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_lockwait = lw;
        hs = -1;
        for (int g = 0; g < 50 && hs < 0; g++) begin
            @(negedge PCLK);
            if (cmd_ready) hs = cyc;
            @(posedge PCLK); #1;
        end
        cmd_valid = 1'b0;
        if (hs < 0) begin
            bound_fail("handshake", 50);
        end else begin
            lock_drop_at = (lock_off < 0) ? -1 : hs + lock_off;
            lock_rise_at = (lock_off < 0 || lock_len < 0) ? -1 : hs + lock_off + lock_len;
        end
        for (int i = 0; i < busy_n; i++) begin
            BUSY = 1'b1;
            @(posedge PCLK); #1;
        end
        BUSY = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic wait_rsp(input int limit, input bit noisy, output int rc);
        rc = -1;
        for (int g = 0; g < limit && rc < 0; g++) begin
            @(negedge PCLK);
            if (rsp_valid) rc = cyc;
            @(posedge PCLK); #1;
            if (noisy) BUSY = 1'($urandom_range(0, 1));
        end
        BUSY = 1'b0;
        if (rc < 0) bound_fail("rsp_valid", limit);
    endtask

    task automatic settle_lock();
        lock_drop_at = -1; lock_rise_at = -1; LOCK = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hs, rc, rc2, ones;
        repeat (3) @(posedge PCLK);
        #1 PRESET_N = 1'b1;
        @(negedge PCLK);
        check("reset cmd_ready", cmd_ready, 1);
        check("reset PSEL", PSEL, 0);
        check("reset PADDR", PADDR, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        @(posedge PCLK); #1;

        // Plain write
        send(1'b1, 6'h15, 8'hA5, 1'b0, 0, -1, -1, hs);
        wait_rsp(20, 1'b0, rc);
        check("write latency", rc - hs, 4);
        check("write SETUP PSEL", log_psel[hs+2], 1);
        check("write SETUP PENABLE", log_pen[hs+2], 0);
        check("write ACCESS PENABLE", log_pen[hs+3], 1);
        check("write PADDR", log_paddr[hs+2], 6'h15);
        check("write PWDATA", log_pwdata[hs+2], 8'hA5);
        check("write PWRITE", log_pwrite[hs+2], 1);
        check("write rsp_rdata", log_rdata[rc], 0);

        // Read with fixed PRDATA
        prdata_fix = 1'b1;
        send(1'b0, 6'h3F, 8'h00, 1'b0, 0, -1, -1, hs);
        wait_rsp(20, 1'b0, rc);
        prdata_fix = 1'b0;
        check("read rsp_rdata", log_rdata[rc], 8'h5C);
        check("read PWRITE", log_pwrite[hs+2], 0);
        check("read PADDR", log_paddr[hs+3], 6'h3F);

        // BUSY held for 10 cycles after the handshake
        send(1'b1, 6'h01, 8'h11, 1'b0, 10, -1, -1, hs);
        wait_rsp(40, 1'b1, rc);
        ones = 0;
        for (int i = hs + 1; i <= hs + 11; i++) ones += int'(log_psel[i]);
        check("busy PSEL low cycles", ones, 0);
        check("busy SETUP after release", log_psel[hs+12], 1);
        check("busy latency", rc - hs, 14);

        // Lock drops during ACCESS and returns 100 cycles later
        send(1'b1, 6'h20, 8'h7E, 1'b1, 0, 3, 100, hs);
        wait_rsp(200, 1'b0, rc);
        check("lock latency", rc - hs, 106);
        check("lock rsp_lock_ok", log_lock_ok[rc], 1);
        check("lock rsp_timeout", log_tmo[rc], 0);
        settle_lock();

        // Lock never drops: the drop window expires, then lock is seen
        send(1'b1, 6'h21, 8'h01, 1'b1, 0, -1, -1, hs);
        wait_rsp(40, 1'b0, rc);
        check("nodrop latency", rc - hs, 13);
        check("nodrop rsp_lock_ok", log_lock_ok[rc], 1);

`ifdef CCC_CFG_LOCK_TIMEOUT_EN
        // Lock lost for good: timeout after LOCK_TIMEOUT cycles of lock wait
        send(1'b1, 6'h22, 8'h02, 1'b1, 0, 2, -1, hs);
        wait_rsp(120, 1'b0, rc);
        check("timeout latency", rc - hs, 54);
        check("timeout rsp_timeout", log_tmo[rc], 1);
        check("timeout rsp_lock_ok", log_lock_ok[rc], 0);
        settle_lock();
`endif

        // cmd_valid held high: only accepted from IDLE
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h2A; cmd_wdata = 8'h3C;
        cmd_lockwait = 1'b0;
        rc = -1; rc2 = -1;
        for (int g = 0; g < 40 && rc2 < 0; g++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                if (rc < 0) rc = cyc;
                else rc2 = cyc;
            end
            @(posedge PCLK); #1;
        end
        cmd_valid = 1'b0;
        if (rc2 < 0) bound_fail("held-valid second rsp", 40);
        else check("held-valid rsp spacing", rc2 - rc, 5);

        // Reset during ACCESS
        send(1'b1, 6'h0F, 8'hF0, 1'b0, 0, -1, -1, hs);
        @(posedge PCLK); #1;
        PRESET_N = 1'b0;
        @(posedge PCLK); #1;
        PRESET_N = 1'b1;
        @(negedge PCLK);
        check("abort PSEL", PSEL, 0);
        check("abort rsp_valid", rsp_valid, 0);
        check("abort cmd_ready", cmd_ready, 1);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            ones += int'(rsp_valid);
        end
        check("abort no rsp", ones, 0);
        @(posedge PCLK); #1;

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            bit w, lw;
            int off, len;
            w   = 1'($urandom_range(0, 1));
            lw  = 1'($urandom_range(0, 1));
            off = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(2, 6));
            len = int'($urandom_range(1, 30));
            send(w, 6'($urandom), 8'($urandom), lw, int'($urandom_range(0, 4)), off, len, hs);
            wait_rsp(120, 1'b1, rc);
            settle_lock();
            repeat ($urandom_range(0, 3)) @(posedge PCLK);
            #1;
        end

        repeat (4) @(posedge PCLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ccc_apb_cfg_master.md
CCC_APB_CFG_MASTER -- requirements
Module: ccc_apb_cfg_master

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 65535, giving the lock-wait limit in PCLK cycles (1..65535).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the number of LOCK synchronizer flops (2..3).
REQ-003 PCLK  input  1  sole clock; all logic on the rising edge.
REQ-004 PRESET_N  input  1  reset, synchronous and active-low.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-006 cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-007 cmd_addr  input  6  CCC register address; cmd_wdata  input  8  write data.
REQ-008 cmd_lockwait  input  1  after the write, wait for the CCC to re-lock.
REQ-009 rsp_valid  output  1  one-cycle pulse that completes each command.
REQ-010 rsp_rdata  output  8  read data, 0 for writes; rsp_lock_ok / rsp_timeout  output  1 / 1  lock-wait outcome.
REQ-011 PSEL, PENABLE, PWRITE  output  1 each; PADDR  output  6; PWDATA  output  8  APB initiator to the CCC.
REQ-012 PRDATA  input  8; BUSY  input  1; LOCK  input  1 (asynchronous)  CCC responder signals.

Function
REQ-013 SHALL implement the states IDLE, WAIT_BUSY, SETUP, ACCESS, LOCK_WAIT and RESP.
REQ-014 IDLE: cmd_ready=1 only here; on cmd_valid&&cmd_ready, latch all cmd_* fields and go to WAIT_BUSY.
REQ-015 WAIT_BUSY: stay while BUSY=1; when BUSY=0, go to SETUP on the next edge.
REQ-016 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values; lasts exactly 1 cycle, then ACCESS.
REQ-017 ACCESS: PSEL=1, PENABLE=1, lasts exactly 1 cycle (no PREADY); for reads, capture PRDATA at the end of ACCESS.
REQ-018 After ACCESS, go to LOCK_WAIT if write && lockwait, else go to RESP.
REQ-019 Outside SETUP/ACCESS, PSEL=PENABLE=0; PADDR/PWRITE/PWDATA hold their last values.
REQ-020 LOCK SHALL pass through a SYNC_STAGES-flop synchronizer (lock_s); lock_s alone is used internally.
REQ-021 LOCK_WAIT: first wait for lock_s=0 or 8 cycles to elapse (drop window), then wait for lock_s=1.
REQ-022 When lock_s=1 in the second phase: rsp_lock_ok=1, then RESP.
REQ-023 RESP: rsp_valid=1 for 1 cycle, then IDLE; rsp_* fields hold until the next RESP.
REQ-024 Command latency without lock wait: 4 cycles from handshake to rsp_valid when BUSY=0 (WAIT_BUSY, SETUP, ACCESS, RESP).
REQ-025 A command presented while not in IDLE SHALL NOT be accepted; cmd_valid may stay high.
REQ-026 BUSY rising during SETUP/ACCESS SHALL be ignored; a started transfer always completes.

Reset
REQ-027 PRESET_N=0 at a clock edge: state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_lock_ok=0, rsp_timeout=0, synchronizer and counters=0.
REQ-028 Reset mid-transfer SHALL abort with no rsp_valid; cmd_ready=1 on the first cycle after release.

Configuration
REQ-029 With CCC_CFG_LOCK_TIMEOUT_EN defined: a 16-bit counter runs during LOCK_WAIT; at LOCK_TIMEOUT cycles without lock, set rsp_timeout=1, rsp_lock_ok=0, go to RESP.
REQ-030 Without CCC_CFG_LOCK_TIMEOUT_EN: no counter; LOCK_WAIT waits indefinitely; rsp_timeout is tied to 0.

Structure
REQ-031 A shared package ccc_cfg_pkg SHALL hold the state enum, CCC_ADDR_W=6, CCC_DATA_W=8, LOCK_DROP_CYCLES=8.
REQ-032 The LOCK synchronizer SHALL be the sub-module ccc_lock_sync; the FSM, APB drive and counters SHALL be in ccc_apb_cfg_master.

Verification
REQ-033 Write addr 0x15 data 0xA5, lockwait=0, BUSY=0 -> SETUP then ACCESS with PADDR=0x15, PWDATA=0xA5, PWRITE=1; rsp_valid 4 cycles after the handshake; rsp_rdata=0.
REQ-034 Read addr 0x3F, PRDATA=0x5C during ACCESS -> rsp_rdata=0x5C, PWRITE=0.
REQ-035 BUSY=1 for 10 cycles after the handshake -> PSEL stays 0 for those 10 cycles; SETUP follows on the first cycle after BUSY falls.
REQ-036 Write with lockwait=1; LOCK drops, then rises 100 cycles later -> rsp_lock_ok=1, rsp_timeout=0.
REQ-037 With the macro defined and LOCK_TIMEOUT=50, LOCK held at 0 -> rsp_timeout=1 about 50 cycles into LOCK_WAIT.
REQ-038 PRESET_N=0 asserted during ACCESS -> PSEL=0 on the next edge, no rsp_valid, IDLE after release.
